// File: rtl/stopwatch_seconds_stage.sv
// ---------------------------------------------------------------------------
// stopwatch_seconds_stage
//
// Seconds stage of a stopwatch.  A small IDLE/RUNNING/PAUSED FSM gates a
// prescaler that divides clk down to one tick per second.  The prescaler
// drives a 0..59 seconds counter.  The counter sends a one-cycle min_enable
// pulse on every 59->0 wrap.  It sends a one-cycle min_clear pulse on clear
// and on reset, so that a downstream minutes counter stays in step.
//
// Parameters:
//   TICKS_PER_SEC  clk cycles per second (2 and up)
//   PRESC_W        prescaler width; TICKS_PER_SEC-1 must fit in it
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       start/resume command (single-cycle pulse)
//   stop        pause command (single-cycle pulse)
//   clear_cmd   zero-and-idle command (single-cycle pulse)
//   seconds     current seconds, 0..59, registered
//   min_enable  one-cycle count enable for the minutes counter
//   min_clear   one-cycle synchronous clear for the minutes counter
//   running     high while the FSM is in RUNNING
//   state       FSM state: IDLE=00, RUNNING=01, PAUSED=10
// ---------------------------------------------------------------------------
module stopwatch_seconds_stage #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PRESC_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_cmd,
  output logic [5:0] seconds,
  output logic       min_enable,
  output logic       min_clear,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_t;

  localparam logic [PRESC_W-1:0] TERMINAL = PRESC_W'(TICKS_PER_SEC - 1);

  state_t             cur_state;
  logic [PRESC_W-1:0] prescaler;

  assign state = cur_state;

  // All state, counters and outputs are held in this one clocked process.
  // Every output comes straight from a flop, so no input has a combinational
  // path to an output.  clear_cmd is checked before the per-state logic, so
  // clear_cmd has priority over stop, and stop has priority over start.  A
  // stop or clear_cmd on the terminal-count edge therefore blocks the
  // increment and the min_enable pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= IDLE;
      prescaler  <= '0;
      seconds    <= '0;
      min_enable <= 1'b0;
      min_clear  <= 1'b1;
      running    <= 1'b0;
    end else begin
      min_enable <= 1'b0;
      min_clear  <= 1'b0;

      if (clear_cmd) begin
        cur_state <= IDLE;
        prescaler <= '0;
        seconds   <= '0;
        min_clear <= 1'b1;
        running   <= 1'b0;
      end else begin
        case (cur_state)
          IDLE: begin
            if (start) begin
              cur_state <= RUNNING;
              running   <= 1'b1;
            end
          end

          RUNNING: begin
            if (stop) begin
              // The prescaler is kept, so a resume continues mid-second.
              cur_state <= PAUSED;
              running   <= 1'b0;
            end else if (prescaler == TERMINAL) begin
              prescaler <= '0;
              // The >= test keeps seconds in 0..59 even from a corrupted value.
              if (seconds >= 6'd59) begin
                seconds    <= 6'd0;
                min_enable <= 1'b1;
              end else begin
                seconds <= seconds + 6'd1;
              end
            end else begin
              prescaler <= prescaler + PRESC_W'(1);
            end
          end

          PAUSED: begin
            if (start) begin
              cur_state <= RUNNING;
              running   <= 1'b1;
            end
          end

          default: begin
            // Encoding 11 cannot be reached. If it appears, fall back to a
            // clean IDLE.
            cur_state <= IDLE;
            prescaler <= '0;
            seconds   <= '0;
            running   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_seconds_stage.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_seconds_stage
//
// Testbench for stopwatch_seconds_stage with TICKS_PER_SEC=4.  Every cycle
// has an expected output record.  The record is pushed when the inputs are
// driven, then popped and compared one time unit after the rising edge.
// Expected values come from hand-derived constants.  For long free-running
// spans, they come from elapsed-cycle arithmetic since the start edge.
// ---------------------------------------------------------------------------
module tb_stopwatch_seconds_stage;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear_cmd = 1'b0;
  logic [5:0] seconds;
  logic       min_enable;
  logic       min_clear;
  logic       running;
  logic [1:0] state;

  typedef struct packed {
    logic [5:0] sec;
    logic       me;
    logic       mc;
    logic       run;
    logic [1:0] st;
  } out_t;

  typedef struct {
    logic rst;
    logic start;
    logic stop;
    logic clr;
    out_t exp;
  } vec_t;

  out_t exp_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  stopwatch_seconds_stage #(
    .TICKS_PER_SEC(TPS),
    .PRESC_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear_cmd (clear_cmd),
    .seconds   (seconds),
    .min_enable(min_enable),
    .min_clear (min_clear),
    .running   (running),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input int sec, input logic me, input logic mc,
                              input logic run, input logic [1:0] st);
    out_t o;
    o.sec = 6'(sec);
    o.me  = me;
    o.mc  = mc;
    o.run = run;
    o.st  = st;
    return o;
  endfunction

  // Expected outputs n cycles after a start edge taken from a zero prescaler
  // with no commands since.
  function automatic out_t runExp(input int n);
    return mk((n / TPS) % 60, (n > 0) && (n % (60 * TPS) == 0), 1'b0, 1'b1, 2'b01);
  endfunction

  task automatic checkOutput(input string name);
    out_t exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got sec=%0d me=%b mc=%b run=%b st=%b",
               name, seconds, min_enable, min_clear, running, state);
      return;
    end
    exp = exp_q.pop_front();
    if (seconds !== exp.sec || min_enable !== exp.me || min_clear !== exp.mc ||
        running !== exp.run || state !== exp.st) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got sec=%0d me=%b mc=%b run=%b st=%b, expected sec=%0d me=%b mc=%b run=%b st=%b",
               name, $time, seconds, min_enable, min_clear, running, state,
               exp.sec, exp.me, exp.mc, exp.run, exp.st);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic c, input out_t exp, input string name);
    @(negedge clk);
    rst       = r;
    start     = s;
    stop      = p;
    clear_cmd = c;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  task automatic runSpan(input int from_n, input int to_n, input string name);
    for (int n = from_n; n <= to_n; n++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, runExp(n), name);
  endtask

  // Watchdog so that a stuck run still reports a failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got %0d checks, required completion", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, then ignored commands, then start and the first two seconds.
    // Inputs in order: rst, start, stop, clr.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 2'b00)});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 1, 0, 2'b00)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00)});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 2'b00)});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 0, 1, 2'b01)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 0, 1, 2'b01)});
    // The prescaler is now 2, so a stop here pauses mid-second.
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 2'b10)});

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].clr,
                    vecs[i].exp, $sformatf("vec%0d", i));

    // Hold while paused. The stop pulses are ignored.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, (i == 3), 1'b0, mk(2, 0, 0, 0, 2'b10), "paused_hold");

    // Resume from prescaler 2, so the increment comes 2 edges later.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, mk(2, 0, 0, 1, 2'b01), "resume");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 0, 1, 2'b01), "resume_p1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, mk(3, 0, 0, 1, 2'b01), "resume_p2");

    // stop+start while RUNNING pauses; clear+start clears to IDLE.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, mk(3, 0, 0, 0, 2'b10), "stop_start");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, mk(0, 0, 1, 0, 2'b00), "clear_start");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00), "clear_after");

    // Long run: two wraps, then stop on the terminal count at seconds=59.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, runExp(0), "long_start");
    runSpan(1, 719, "long_run");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, mk(59, 0, 0, 0, 2'b10), "stop_at_terminal");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, mk(59, 0, 0, 0, 2'b10), "stop_at_terminal_hold");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 1, 0, 2'b00), "clear_from_paused");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00), "clear_from_paused_after");

    // Reset mid-count at seconds=30 discards partial-second progress.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, runExp(0), "mid_start");
    runSpan(1, 122, "mid_run");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 2'b00), "rst_mid_run");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00), "rst_release");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, runExp(0), "restart");
    runSpan(1, 4, "restart_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
